ram_access_sequencer: RTL and testbench

//  Downstream of the megarom controller's RAM port: turns level-type OE_n/WE_n/RFSH_n

---
 rtl/ram_access_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_ram_access_sequencer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer
//
// Sits behind the megarom controller's RAM port and converts its level-type
// strobes (HOST_OE_n / HOST_WE_n / HOST_RFSH_n) into single-shot REQ/ACK
// transactions towards a PSRAM/SDRAM controller.
//
// - A falling strobe, seen while idle, starts exactly one transaction.
//   A write wins over a simultaneous read. A refresh runs only when no
//   read or write is starting.
// - Read data is latched on MEM_ACK and presented on HOST_DOUT for as long
//   as HOST_OE_n stays low. HOST_DOUT is 0 whenever HOST_OE_n is high, so
//   it can be OR-ed onto a shared bus.
// - WAIT_n stalls the MSX bus while a read is outstanding. Writes are posted.
// - A refresh strobe that falls while busy is remembered (one deep) and is
//   served on the next return to idle.
// - An 8-bit timer aborts a request that is not acknowledged in time and
//   sets the sticky ERR flag. The request stays high for TIMEOUT+1 cycles
//   (timer values 0..TIMEOUT). An ACK in the last of those cycles still
//   counts as a normal completion.
//
// Ports
//   CLK, RESET              clock; asynchronous active-high reset
//   HOST_ADDR, HOST_DIN     address / write data from the megarom controller
//   HOST_WE_n, HOST_OE_n,   active-low write / read / refresh strobes
//   HOST_RFSH_n
//   HOST_DOUT               read data (0 when not driving)
//   WAIT_n                  active-low bus wait request
//   ERR                     sticky timeout flag
//   MEM_REQ, MEM_WE,        access request towards the memory controller
//   MEM_ADDR, MEM_WDATA
//   MEM_ACK, MEM_RDATA      access done / read data (valid with MEM_ACK)
//   MEM_RFSH_REQ,           refresh request / done
//   MEM_RFSH_ACK

module ram_access_sequencer #(
    parameter int ADDR_BITS = 22,
    parameter int TIMEOUT   = 63,
    parameter bit WAIT_EN   = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [ADDR_BITS-1:0] HOST_ADDR,
    input  logic [7:0]           HOST_DIN,
    input  logic                 HOST_WE_n,
    input  logic                 HOST_OE_n,
    input  logic                 HOST_RFSH_n,
    output logic [7:0]           HOST_DOUT,
    output logic                 WAIT_n,
    output logic                 ERR,
    output logic                 MEM_REQ,
    output logic                 MEM_WE,
    output logic [ADDR_BITS-1:0] MEM_ADDR,
    output logic [7:0]           MEM_WDATA,
    input  logic                 MEM_ACK,
    input  logic [7:0]           MEM_RDATA,
    output logic                 MEM_RFSH_REQ,
    input  logic                 MEM_RFSH_ACK
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        WR_REQ,
        RF_REQ,
        HOLD
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t               state;
    state_t               next_state;

    logic                 prev_we;
    logic                 prev_oe;
    logic                 prev_rfsh;
    logic                 we_fall;
    logic                 oe_fall;
    logic                 rfsh_fall;

    logic                 rfsh_pending;
    logic                 discard;      // strobe was released during the current request
    logic                 err_flag;
    logic [7:0]           timer;
    logic [7:0]           rdata_hold;
    logic [7:0]           wdata_reg;
    logic [ADDR_BITS-1:0] addr_reg;

    logic                 in_req;
    logic                 ack_now;
    logic                 timed_out;
    logic                 abort;
    logic                 strobe_up;
    logic                 abandon;
    logic                 stay;

    // ------------------------------------------------------------------
    // Strobe edge detection and request-status decode
    // ------------------------------------------------------------------
    assign we_fall   = prev_we   & ~HOST_WE_n;
    assign oe_fall   = prev_oe   & ~HOST_OE_n;
    assign rfsh_fall = prev_rfsh & ~HOST_RFSH_n;

    // NOTE: every signal driven from always_comb gets a default value first,
    // so no path through the case statements can leave it unassigned (latch).
    always_comb begin
        in_req    = 1'b0;
        ack_now   = 1'b0;
        strobe_up = 1'b0;
        case (state)
            RD_REQ: begin
                in_req    = 1'b1;
                ack_now   = MEM_ACK;
                strobe_up = HOST_OE_n;
            end
            WR_REQ: begin
                in_req    = 1'b1;
                ack_now   = MEM_ACK;
                strobe_up = HOST_WE_n;
            end
            RF_REQ: begin
                in_req    = 1'b1;
                ack_now   = MEM_RFSH_ACK;
            end
            default: ;
        endcase
        timed_out = in_req && (timer == TIMEOUT_CNT);
        abort     = timed_out && !ack_now;
        // A released strobe stays released for the rest of the request,
        // even if the host drops it again before the ACK.
        abandon   = discard | strobe_up;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (we_fall) begin
                    next_state = WR_REQ;
                end else if (oe_fall) begin
                    next_state = RD_REQ;
                end else if (rfsh_pending || rfsh_fall) begin
                    next_state = RF_REQ;
                end
            end
            RD_REQ, WR_REQ: begin
                if (MEM_ACK) begin
                    // Host already gone: complete the handshake, skip HOLD.
                    next_state = abandon ? IDLE : HOLD;
                end else if (timed_out) begin
                    next_state = HOLD;
                end
            end
            RF_REQ: begin
                if (MEM_RFSH_ACK || timed_out) begin
                    next_state = IDLE;
                end
            end
            HOLD: begin
                if (HOST_OE_n && HOST_WE_n) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        MEM_REQ      = (state == RD_REQ) || (state == WR_REQ);
        MEM_WE       = (state == WR_REQ);
        MEM_RFSH_REQ = (state == RF_REQ);
        MEM_ADDR     = addr_reg;
        MEM_WDATA    = wdata_reg;
        ERR          = err_flag;
        // Gated by the live strobe so the bus is released in the same cycle.
        HOST_DOUT    = HOST_OE_n ? 8'h00 : rdata_hold;
        WAIT_n       = !(WAIT_EN && (state == RD_REQ) && !abandon);
    end

    // ------------------------------------------------------------------
    // Datapath: strobe history, latched request, timer, flags, read data
    // ------------------------------------------------------------------
    assign stay = in_req && (next_state == state);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_we      <= 1'b1;
            prev_oe      <= 1'b1;
            prev_rfsh    <= 1'b1;
            addr_reg     <= '0;
            wdata_reg    <= 8'h00;
            timer        <= 8'h00;
            discard      <= 1'b0;
            err_flag     <= 1'b0;
            rfsh_pending <= 1'b0;
            rdata_hold   <= 8'h00;
        end else begin
            prev_we   <= HOST_WE_n;
            prev_oe   <= HOST_OE_n;
            prev_rfsh <= HOST_RFSH_n;

            if (state == IDLE && we_fall) begin
                addr_reg  <= HOST_ADDR;
                wdata_reg <= HOST_DIN;
            end else if (state == IDLE && oe_fall) begin
                addr_reg  <= HOST_ADDR;
            end

            // Zero outside request states, so each request starts at 0.
            timer   <= stay ? timer + 8'd1 : 8'd0;
            discard <= stay ? abandon : 1'b0;

            if (abort) begin
                err_flag <= 1'b1;
            end

            // Completion wins over a coincident fall: that fall is covered
            // by the refresh that is just finishing.
            if (state == RF_REQ && next_state == IDLE) begin
                rfsh_pending <= 1'b0;
            end else if (rfsh_fall) begin
                rfsh_pending <= 1'b1;
            end

            if (state == RD_REQ && MEM_ACK && !abandon) begin
                rdata_hold <= MEM_RDATA;
            end else if (state == RD_REQ && abort) begin
                rdata_hold <= 8'hFF;
            end else if (!(state == HOLD && next_state == HOLD)) begin
                rdata_hold <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Testbench for ram_access_sequencer.
//
// The bench drives the host strobes and plays the memory controller. The
// memory responder's ACK timing comes from the bench's own transaction
// model, not from the DUT outputs. Every cycle, the bench compares all DUT
// outputs with that model. Directed scenarios add hand-computed literal
// expectations. A randomized phase follows them.

module tb_ram_access_sequencer;

    localparam int ADDR_BITS = 22;
    localparam int TIMEOUT   = 63;
    localparam int NEVER     = 255;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [ADDR_BITS-1:0] HOST_ADDR;
    logic [7:0]           HOST_DIN;
    logic                 HOST_WE_n;
    logic                 HOST_OE_n;
    logic                 HOST_RFSH_n;
    logic [7:0]           HOST_DOUT;
    logic                 WAIT_n;
    logic                 ERR;
    logic                 MEM_REQ;
    logic                 MEM_WE;
    logic [ADDR_BITS-1:0] MEM_ADDR;
    logic [7:0]           MEM_WDATA;
    logic                 MEM_ACK;
    logic [7:0]           MEM_RDATA;
    logic                 MEM_RFSH_REQ;
    logic                 MEM_RFSH_ACK;

    ram_access_sequencer #(
        .ADDR_BITS(ADDR_BITS),
        .TIMEOUT  (TIMEOUT),
        .WAIT_EN  (1'b1)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .HOST_ADDR   (HOST_ADDR),
        .HOST_DIN    (HOST_DIN),
        .HOST_WE_n   (HOST_WE_n),
        .HOST_OE_n   (HOST_OE_n),
        .HOST_RFSH_n (HOST_RFSH_n),
        .HOST_DOUT   (HOST_DOUT),
        .WAIT_n      (WAIT_n),
        .ERR         (ERR),
        .MEM_REQ     (MEM_REQ),
        .MEM_WE      (MEM_WE),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_ACK     (MEM_ACK),
        .MEM_RDATA   (MEM_RDATA),
        .MEM_RFSH_REQ(MEM_RFSH_REQ),
        .MEM_RFSH_ACK(MEM_RFSH_ACK)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Stimulus for the next cycle
    logic                 drv_oe, drv_we, drv_rf;
    logic [ADDR_BITS-1:0] drv_addr;
    logic [7:0]           drv_din;
    logic [7:0]           ack_rdata;
    int                   next_lat;     // ACK latency for the next read/write
    int                   next_rlat;    // ACK latency for the next refresh

    // Transaction-level model of the host side
    typedef enum {K_NONE, K_READ, K_WRITE, K_RFSH} kind_t;
    kind_t                m_kind;
    bit                   m_hold;       // access finished, waiting for strobes to release
    bit                   m_rel;        // host let go of the strobe during the request
    bit                   m_pend;
    bit                   m_err;
    int                   m_waited;
    int                   m_lat;
    logic [7:0]           m_byte;
    logic [ADDR_BITS-1:0] m_addr;
    logic [7:0]           m_wdata;
    bit                   m_poe, m_pwe, m_prf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_kind   = K_NONE;
        m_hold   = 0;
        m_rel    = 0;
        m_pend   = 0;
        m_err    = 0;
        m_waited = 0;
        m_lat    = 0;
        m_byte   = 8'h00;
        m_addr   = '0;
        m_wdata  = 8'h00;
        m_poe    = 1;
        m_pwe    = 1;
        m_prf    = 1;
    endtask

    function automatic bit rw_outstanding();
        return (m_kind == K_READ || m_kind == K_WRITE) && !m_hold;
    endfunction

    task automatic start_rw(input kind_t k);
        m_kind   = k;
        m_hold   = 0;
        m_rel    = 0;
        m_waited = 0;
        m_lat    = next_lat;
        m_addr   = HOST_ADDR;
        if (k == K_WRITE) m_wdata = HOST_DIN;
    endtask

    // Compare DUT outputs with the model, then advance the model by one cycle.
    task automatic compare_and_step();
        bit         out_rw;
        bit         e_wait;
        logic [7:0] e_dout;
        bit         oe_f, we_f, rf_f, up, rel;

        out_rw = rw_outstanding();
        e_wait = !(out_rw && m_kind == K_READ && !(m_rel || HOST_OE_n));
        e_dout = (!HOST_OE_n && m_hold) ? m_byte : 8'h00;
        check("mem_req",  MEM_REQ,      out_rw);
        check("mem_we",   MEM_WE,       out_rw && m_kind == K_WRITE);
        check("rfsh_req", MEM_RFSH_REQ, m_kind == K_RFSH);
        check("mem_addr", MEM_ADDR,     m_addr);
        check("wdata",    MEM_WDATA,    m_wdata);
        check("wait_n",   WAIT_n,       e_wait);
        check("dout",     HOST_DOUT,    e_dout);
        check("err",      ERR,          m_err);

        oe_f = m_poe && !HOST_OE_n;
        we_f = m_pwe && !HOST_WE_n;
        rf_f = m_prf && !HOST_RFSH_n;
        case (m_kind)
            K_NONE: begin
                if (we_f) start_rw(K_WRITE);
                else if (oe_f) start_rw(K_READ);
                else if (m_pend || rf_f) begin
                    m_kind   = K_RFSH;
                    m_waited = 0;
                    m_lat    = next_rlat;
                end
                m_pend = m_pend | rf_f;
            end
            K_RFSH: begin
                if (MEM_RFSH_ACK || m_waited == TIMEOUT) begin
                    if (!MEM_RFSH_ACK) m_err = 1;
                    m_kind = K_NONE;
                    m_pend = 0;
                end else begin
                    m_waited++;
                    m_pend = m_pend | rf_f;
                end
            end
            default: begin
                if (m_hold) begin
                    if (HOST_OE_n && HOST_WE_n) begin
                        m_kind = K_NONE;
                        m_hold = 0;
                    end
                end else begin
                    up  = (m_kind == K_READ) ? HOST_OE_n : HOST_WE_n;
                    rel = m_rel || up;
                    if (MEM_ACK) begin
                        if (rel) m_kind = K_NONE;
                        else begin
                            m_hold = 1;
                            m_byte = (m_kind == K_READ) ? MEM_RDATA : 8'h00;
                        end
                    end else if (m_waited == TIMEOUT) begin
                        m_err  = 1;
                        m_hold = 1;
                        m_byte = (m_kind == K_READ) ? 8'hFF : 8'h00;
                    end else begin
                        m_waited++;
                        m_rel = rel;
                    end
                end
                m_pend = m_pend | rf_f;
            end
        endcase
        m_poe = HOST_OE_n;
        m_pwe = HOST_WE_n;
        m_prf = HOST_RFSH_n;
    endtask

    // One clock cycle: drive after the rising edge, check on the falling edge.
    task automatic cycle();
        bit ack, rack;
        @(posedge CLK);
        #1;
        cyc++;
        ack  = rw_outstanding() && m_waited == m_lat;
        rack = (m_kind == K_RFSH) && m_waited == m_lat;
        HOST_OE_n    = drv_oe;
        HOST_WE_n    = drv_we;
        HOST_RFSH_n  = drv_rf;
        HOST_ADDR    = drv_addr;
        HOST_DIN     = drv_din;
        MEM_ACK      = ack;
        MEM_RFSH_ACK = rack;
        MEM_RDATA    = ack ? ack_rdata : 8'($urandom);
        @(negedge CLK);
        compare_and_step();
    endtask

    task automatic idle(input int n);
        drv_oe = 1;
        drv_we = 1;
        drv_rf = 1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_values();
        check("rst_req",   MEM_REQ,      0);
        check("rst_we",    MEM_WE,       0);
        check("rst_rfsh",  MEM_RFSH_REQ, 0);
        check("rst_addr",  MEM_ADDR,     0);
        check("rst_wdata", MEM_WDATA,    0);
        check("rst_dout",  HOST_DOUT,    0);
        check("rst_wait",  WAIT_n,       1);
        check("rst_err",   ERR,          0);
    endtask

    initial begin
        int cnt, cnt2, first_rf;
        logic prev_rfreq;

        RESET        = 1;
        HOST_OE_n    = 1;
        HOST_WE_n    = 1;
        HOST_RFSH_n  = 1;
        HOST_ADDR    = '0;
        HOST_DIN     = 8'h00;
        MEM_ACK      = 0;
        MEM_RDATA    = 8'h00;
        MEM_RFSH_ACK = 0;
        drv_oe = 1; drv_we = 1; drv_rf = 1;
        drv_addr = '0; drv_din = 8'h00; ack_rdata = 8'h00;
        next_lat = 1; next_rlat = 1;
        model_reset();
        #3;
        check_reset_values();
        @(negedge CLK);
        RESET = 0;
        idle(3);

        // 1. Read at 0x012345, ACK 3 cycles after REQ with 0xA5
        next_lat  = 3;
        ack_rdata = 8'hA5;
        drv_addr  = 22'h012345;
        drv_oe    = 0;
        cycle();
        check("t1_no_req_in_fall_cycle", MEM_REQ, 0);
        cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            if (!WAIT_n) cnt++;
            if (i == 1) begin
                check("t1_req", MEM_REQ, 1);
                check("t1_we", MEM_WE, 0);
                check("t1_addr", MEM_ADDR, 22'h012345);
            end
            if (i == 5) begin
                check("t1_req_dropped", MEM_REQ, 0);
                check("t1_dout", HOST_DOUT, 8'hA5);
            end
        end
        check("t1_wait_cycles", cnt, 4);
        drv_oe = 1;
        cycle();
        check("t1_dout_released", HOST_DOUT, 0);
        idle(2);

        // 2. Posted write of 0x3C to 0x000010, ACK after 2 cycles
        next_lat = 2;
        drv_addr = 22'h000010;
        drv_din  = 8'h3C;
        drv_we   = 0;
        cycle();
        cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            cycle();
            drv_din = 8'($urandom);
            if (i <= 3) begin
                check("t2_req", MEM_REQ, 1);
                check("t2_we", MEM_WE, 1);
                check("t2_wdata", MEM_WDATA, 8'h3C);
                check("t2_addr", MEM_ADDR, 22'h000010);
                check("t2_wait", WAIT_n, 1);
            end else if (MEM_REQ) begin
                cnt++;
            end
        end
        check("t2_no_second_req", cnt, 0);
        idle(2);

        // 3. Two refresh falls during a read -> one refresh after the read
        next_lat  = 6;
        next_rlat = 1;
        drv_addr  = 22'h2ABCDE;
        drv_oe    = 0;
        cycle();
        cnt = 0;
        first_rf = -1;
        prev_rfreq = 0;
        for (int i = 1; i <= 30; i++) begin
            drv_rf = (i == 2 || i == 4) ? 1'b0 : 1'b1;
            drv_oe = (i >= 10) ? 1'b1 : 1'b0;
            cycle();
            if (MEM_RFSH_REQ && !prev_rfreq) cnt++;
            if (MEM_RFSH_REQ && first_rf < 0) first_rf = i;
            prev_rfreq = MEM_RFSH_REQ;
        end
        check("t3_rfsh_count", cnt, 1);
        check("t3_rfsh_first_cycle", first_rf, 12);
        check("t3_err_clear", ERR, 0);
        idle(2);

        // 4. Read that is never acknowledged
        next_lat = NEVER;
        drv_addr = 22'h001234;
        drv_oe   = 0;
        cycle();
        cnt = 0;
        for (int i = 1; i <= 70; i++) begin
            cycle();
            if (MEM_REQ) cnt++;
            if (i == 65) begin
                check("t4_err", ERR, 1);
                check("t4_dout_ff", HOST_DOUT, 8'hFF);
                check("t4_wait", WAIT_n, 1);
            end
        end
        check("t4_req_cycles", cnt, TIMEOUT + 1);
        idle(2);

        // 5. Simultaneous OE and WE fall -> one write, no read data
        next_lat = 1;
        drv_addr = 22'h000777;
        drv_din  = 8'h81;
        drv_oe   = 0;
        drv_we   = 0;
        cycle();
        cnt  = 0;
        cnt2 = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (MEM_REQ) cnt++;
            if (MEM_REQ && !MEM_WE) cnt2++;
            if (i == 6) check("t5_dout_zero", HOST_DOUT, 0);
        end
        check("t5_req_cycles", cnt, 2);
        check("t5_read_req_cycles", cnt2, 0);
        idle(2);
        check("t5_err_sticky", ERR, 1);

        // 6. Asynchronous reset while REQ is high
        next_lat = NEVER;
        drv_addr = 22'h3FFFFF;
        drv_oe   = 0;
        cycle();
        for (int i = 1; i <= 3; i++) cycle();
        check("t6_req_before_reset", MEM_REQ, 1);
        #1;
        RESET = 1;
        #1;
        check_reset_values();
        HOST_OE_n = 1;
        drv_oe    = 1;
        model_reset();
        #1;
        RESET = 0;
        idle(2);
        next_lat  = 2;
        ack_rdata = 8'h5A;
        drv_addr  = 22'h000042;
        drv_oe    = 0;
        cycle();
        for (int i = 1; i <= 4; i++) begin
            cycle();
            if (i == 1) begin
                check("t6_clean_req", MEM_REQ, 1);
                check("t6_clean_addr", MEM_ADDR, 22'h000042);
            end
            if (i == 4) check("t6_clean_dout", HOST_DOUT, 8'h5A);
        end
        idle(3);

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            if (drv_oe) drv_oe = ($urandom_range(0, 7) != 0);
            else        drv_oe = ($urandom_range(0, 5) == 0);
            if (drv_we) drv_we = ($urandom_range(0, 9) != 0);
            else        drv_we = ($urandom_range(0, 4) == 0);
            if (drv_rf) drv_rf = ($urandom_range(0, 11) != 0);
            else        drv_rf = ($urandom_range(0, 1) == 0);
            drv_addr  = ADDR_BITS'($urandom);
            drv_din   = 8'($urandom);
            ack_rdata = 8'($urandom);
            next_lat  = ($urandom_range(0, 39) == 0) ? NEVER : int'($urandom_range(0, 6));
            next_rlat = ($urandom_range(0, 59) == 0) ? NEVER : int'($urandom_range(0, 4));
            cycle();
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
